// File: rtl/dma_pkg.sv
// Shared AXI constants, state encoding and helpers for the DMA read-path command logic.
// Pure declarations: no latency, no flow control.
package dma_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam int         AXI_4K_BYTES   = 4096;

  typedef logic [1:0] dma_state_t;

  localparam dma_state_t ST_IDLE  = 2'd0;
  localparam dma_state_t ST_CALC  = 2'd1;
  localparam dma_state_t ST_ISSUE = 2'd2;
  localparam dma_state_t ST_DONE  = 2'd3;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/dma_burst_calc.sv
// Burst sizer: beats = min(remaining, MAX_BURST, beats left before the next 4 KB line).
// Purely combinational, no backpressure.
module dma_burst_calc
  import dma_pkg::*;
#(
  parameter int LEN_WIDTH = 16,
  parameter int BYTES     = 8,
  parameter int MAX_BURST = 256
) (
  input  logic [11:0]          addr_lo,
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [8:0]           burst
);

  // Wide enough that neither the beat count nor the 4 KB distance is clipped before the min.
  localparam int CW  = ((LEN_WIDTH > 13) ? LEN_WIDTH : 13) + 1;
  localparam int OFF = clog2(BYTES);

  logic [12:0]   bytes_to_4k;
  logic [12:0]   to4k;
  logic [CW-1:0] rem_w;
  logic [CW-1:0] max_w;
  logic [CW-1:0] to4k_w;
  logic [CW-1:0] min_a;

  always_comb begin
    bytes_to_4k = 13'(AXI_4K_BYTES) - {1'b0, addr_lo};
    to4k        = bytes_to_4k >> OFF;
    rem_w       = CW'(remaining);
    max_w       = CW'(MAX_BURST);
    to4k_w      = CW'(to4k);
    min_a       = (rem_w < max_w) ? rem_w : max_w;
    burst       = 9'((min_a < to4k_w) ? min_a : to4k_w);
  end

endmodule

// File: rtl/dma_rd_cmd_gen.sv
// Splits one read descriptor into 4 KB-safe AXI AR bursts; first ARVALID two cycles after accept, one CALC cycle between bursts.
// AR fields are held stable while ARREADY is low; cmd_ready is only high in IDLE, so one descriptor is in flight.
module dma_rd_cmd_gen
  import dma_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 4,
  parameter int DATA_WIDTH = 64,
  parameter int LEN_WIDTH  = 16,
  parameter int MAX_BURST  = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ID_WIDTH-1:0]   cmd_id,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  busy,
  output logic                  done,
  output logic [ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = clog2(BYTES);
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTES - 1);

  dma_state_t            state;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [8:0]            burst_q;
  logic [8:0]            burst_nxt;

  dma_burst_calc #(
    .LEN_WIDTH (LEN_WIDTH),
    .BYTES     (BYTES),
    .MAX_BURST (MAX_BURST)
  ) u_burst_calc (
    .addr_lo   (addr_q[11:0]),
    .remaining (rem_q),
    .burst     (burst_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      id_q         <= '0;
      addr_q       <= '0;
      rem_q        <= '0;
      burst_q      <= '0;
      M_AXI_ARID   <= '0;
      M_AXI_ARADDR <= '0;
      M_AXI_ARLEN  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            id_q   <= cmd_id;
            addr_q <= cmd_addr & ALIGN_MASK;
            rem_q  <= cmd_len;
            state  <= (cmd_len == '0) ? ST_DONE : ST_CALC;
          end
        end
        ST_CALC: begin
          burst_q      <= burst_nxt;
          M_AXI_ARID   <= id_q;
          M_AXI_ARADDR <= addr_q;
          M_AXI_ARLEN  <= 8'(burst_nxt - 9'd1);
          state        <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (M_AXI_ARREADY) begin
            // burst never exceeds rem_q, so narrowing burst_q to LEN_WIDTH is lossless.
            addr_q <= addr_q + (ADDR_WIDTH'(burst_q) << OFF);
            rem_q  <= rem_q - LEN_WIDTH'(burst_q);
            state  <= (rem_q == LEN_WIDTH'(burst_q)) ? ST_DONE : ST_CALC;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready     = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_DONE);
  assign M_AXI_ARVALID = (state == ST_ISSUE);
  assign M_AXI_ARSIZE  = 3'(OFF);
  assign M_AXI_ARBURST = AXI_BURST_INCR;

endmodule

// File: doc/dma_rd_cmd_gen.md
Name: dma_rd_cmd_gen

Overview:
Parametrised AXI4 read-address command generator for the DMA read path. It accepts one transfer descriptor (ID, start address, length in beats) over a valid/ready handshake and splits it into AR bursts. Each burst is limited by a maximum burst length, by the remaining length, and by the AXI 4 KB boundary. It sits between the DMA descriptor/control logic and the M_AXI AR channel, and drives registered, AXI-stable AR outputs.

Parameters:
ADDR_WIDTH, 32, AXI address width.
ID_WIDTH, 4, AXI ID width.
DATA_WIDTH, 64, AXI data width in bits (8..1024, power of 2); BYTES = DATA_WIDTH/8.
LEN_WIDTH, 16, width of the descriptor beat count.
MAX_BURST, 256, maximum beats per burst (power of 2, 1..256).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  descriptor valid
cmd_ready  out  1  high only in IDLE
cmd_id  in  ID_WIDTH  AXI ID for all bursts of the descriptor
cmd_addr  in  ADDR_WIDTH  byte start address; low log2(BYTES) bits are forced to 0
cmd_len  in  LEN_WIDTH  total beats (actual count; 0 is legal)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the descriptor has fully issued
M_AXI_ARID  out  ID_WIDTH
M_AXI_ARADDR  out  ADDR_WIDTH
M_AXI_ARLEN  out  8  beats-1
M_AXI_ARSIZE  out  3  constant log2(BYTES)
M_AXI_ARBURST  out  2  constant 2'b01 (INCR)
M_AXI_ARVALID  out  1
M_AXI_ARREADY  in  1

Behaviour:
- Reset (rst=1, asynchronous):
  - state=IDLE; all registers cleared.
  - ARVALID=0, ARID/ARADDR/ARLEN=0, done=0, busy=0, cmd_ready=1 once rst releases.
  - Asserting rst mid-burst drops ARVALID immediately; the descriptor is discarded.
- States: IDLE, CALC, ISSUE, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch id, aligned addr and remaining=cmd_len.
  - cmd_len==0 -> DONE; otherwise -> CALC.
- CALC (one cycle, ARVALID=0):
  - to4k = (4096 - addr[11:0]) / BYTES.
  - burst = min(remaining, MAX_BURST, to4k).
  - Register ARADDR=addr, ARLEN=burst-1, ARID=id; -> ISSUE.
  - Arithmetic is unsigned; to4k is computed at 13 bits (value 1..4096/BYTES). Compare at max(LEN_WIDTH,13)+1 bits; no truncation is allowed before the min.
- ISSUE:
  - ARVALID=1. ARID/ARADDR/ARLEN are held stable until ARREADY.
  - On ARVALID&ARREADY: addr += burst*BYTES (wraps modulo 2^ADDR_WIDTH); remaining -= burst.
  - Next state: remaining==burst -> DONE, else CALC.
- DONE (one cycle): done=1, busy=1, cmd_ready=0; -> IDLE.
- Latency:
  - Descriptor accepted at edge T -> ARVALID high from T+2.
  - One idle cycle between consecutive bursts (CALC).
  - done is high one cycle after the last AR handshake.
- Throughput: at most one descriptor in flight; back-to-back descriptors are separated by the DONE cycle.
- No burst ever crosses a 4 KB boundary; every ARLEN ≤ MAX_BURST-1.
- cmd_* inputs are ignored outside IDLE.
- ARREADY asserted while ARVALID=0 has no effect.

Decomposition:
- Shared package (dma_pkg): AXI_BURST_INCR constant, 4 KB boundary constant (AXI_4K_BYTES=4096), function clog2 for ARSIZE, and a typedef for the state enum.
- Sub-module dma_burst_calc: combinational (addr, remaining) -> burst beats, using the min-of-three with the 4 KB split. Unit-testable on its own.

Test Plan (DATA_WIDTH=64, MAX_BURST=256, ARREADY=1 unless stated):
1. addr=0x1000, len=16, id=3 -> single AR: ARADDR=0x1000, ARLEN=15, ARID=3, ARSIZE=3, ARBURST=1; done 1 cycle after the handshake.
2. addr=0x0, len=600 -> ARs (0x0,255), (0x800,255), (0x1000,87); exactly one done pulse.
3. addr=0x0FF0, len=10 -> ARs (0x0FF0,1), (0x1000,7): the 4 KB split.
4. addr=0x2000, len=4 with ARREADY held low 5 cycles -> ARVALID stays 1 and ARADDR/ARLEN/ARID stay constant for all 5 cycles; one handshake; done.
5. len=0 -> no ARVALID; done pulses 1 cycle after accept; cmd_ready returns 1 the cycle after.
6. rst pulsed while ARVALID=1 during test 2 -> ARVALID=0 in the same cycle, no done; the next descriptor (addr=0x40, len=1) issues a clean AR (0x40,0).
